// File: rtl/babbage_poly_engine.sv
// -----------------------------------------------------------------------------
// babbage_poly_engine
//   Evaluates a degree-DEGREE polynomial at point n using the method of finite
//   differences, as Babbage's Difference Engine does. The result is then
//   converted to BCD by double-dabble.
//
//   Ports:
//     clk        - single clock, rising edge
//     reset      - asynchronous active-high reset
//     start      - compute request, sampled only in IDLE
//     n_in       - evaluation point n, latched on accepted start
//     init_diff  - f(0), df(0), ..., d^DEGREE f(0), latched on accepted start
//     busy       - high in every state except IDLE
//     done       - one-cycle pulse while the result is presented (DONE state)
//     result     - binary f(n) mod 2^OUTPUT_WIDTH, held until the next done
//     bcd_out    - BCD digits of result (index 0 = units), held until next done
//     ovf        - sticky overflow of any difference addition
//                  (present only with BABBAGE_OVF_DETECT_EN defined)
//
//   Optional feature macro: BABBAGE_OVF_DETECT_EN
// -----------------------------------------------------------------------------
module babbage_poly_engine #(
  parameter int DEGREE       = 3,
  parameter int OUTPUT_WIDTH = 14,
  parameter int INPUT_WIDTH  = 5,
  parameter int BCD_DIGITS   = 5
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 start,
  input  logic [INPUT_WIDTH-1:0]               n_in,
  input  logic [DEGREE:0][OUTPUT_WIDTH-1:0]    init_diff,
  output logic                                 busy,
  output logic                                 done,
  output logic [OUTPUT_WIDTH-1:0]              result,
  output logic [BCD_DIGITS-1:0][3:0]           bcd_out
`ifdef BABBAGE_OVF_DETECT_EN
  ,
  output logic                                 ovf
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COMPUTE,
    S_BCD,
    S_DONE
  } state_t;

  localparam int BW = $clog2(OUTPUT_WIDTH + 1);

  // Sums carry one extra bit only when the overflow flag needs the carry-out.
`ifdef BABBAGE_OVF_DETECT_EN
  localparam int SUM_W = OUTPUT_WIDTH + 1;
`else
  localparam int SUM_W = OUTPUT_WIDTH;
`endif

  state_t                            r_state;
  state_t                            w_state_next;

  logic [INPUT_WIDTH-1:0]            r_n;
  logic [INPUT_WIDTH-1:0]            r_cnt;
  logic [DEGREE:0][OUTPUT_WIDTH-1:0] r_d;
  logic [OUTPUT_WIDTH-1:0]           r_bin;
  logic [BCD_DIGITS-1:0][3:0]        r_bcd;
  logic [BW-1:0]                     r_bit_cnt;

  logic [SUM_W-1:0]                  w_sum [DEGREE];
  logic [BCD_DIGITS-1:0][3:0]        w_bcd_adj;
  logic [4*BCD_DIGITS:0]             w_bcd_shift;
  logic [BCD_DIGITS-1:0][3:0]        w_bcd_next;
  logic                              w_cnt_hit;
  logic                              w_bcd_last;

`ifdef BABBAGE_OVF_DETECT_EN
  logic                              r_ovf_acc;
  logic                              w_carry;
`endif

  assign w_cnt_hit  = (r_cnt == r_n);
  assign w_bcd_last = (r_bit_cnt == BW'(OUTPUT_WIDTH - 1));

  // Every difference register adds only its own neighbour's old value, so the
  // update path stays a single adder regardless of DEGREE.
  always_comb begin
    for (int unsigned k = 0; k < DEGREE; k++) begin
      w_sum[k] = SUM_W'(r_d[k]) + SUM_W'(r_d[k+1]);
    end
  end

`ifdef BABBAGE_OVF_DETECT_EN
  always_comb begin
    w_carry = 1'b0;
    for (int unsigned k = 0; k < DEGREE; k++) begin
      w_carry = w_carry | w_sum[k][OUTPUT_WIDTH];
    end
  end
`endif

  // Double-dabble step: add 3 to digits above 4, then shift in the binary MSB.
  // Digits shifted past the top digit are dropped (truncated upper digits).
  always_comb begin
    w_bcd_adj = r_bcd;
    for (int unsigned d = 0; d < BCD_DIGITS; d++) begin
      if (r_bcd[d] > 4'd4) begin
        w_bcd_adj[d] = r_bcd[d] + 4'd3;
      end
    end
    w_bcd_shift = {w_bcd_adj, r_bin[OUTPUT_WIDTH-1]};
    w_bcd_next  = w_bcd_shift[4*BCD_DIGITS-1:0];
  end

  // FSM: state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM: next state and Moore outputs
  always_comb begin
    w_state_next = r_state;
    busy         = 1'b1;
    done         = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          w_state_next = S_COMPUTE;
        end
      end
      S_COMPUTE: begin
        if (w_cnt_hit) begin
          w_state_next = S_BCD;
        end
      end
      S_BCD: begin
        if (w_bcd_last) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        done         = 1'b1;
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Datapath
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_n       <= '0;
      r_cnt     <= '0;
      r_d       <= '0;
      r_bin     <= '0;
      r_bcd     <= '0;
      r_bit_cnt <= '0;
      result    <= '0;
      bcd_out   <= '0;
`ifdef BABBAGE_OVF_DETECT_EN
      r_ovf_acc <= 1'b0;
      ovf       <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_n   <= n_in;
            r_d   <= init_diff;
            r_cnt <= '0;
`ifdef BABBAGE_OVF_DETECT_EN
            r_ovf_acc <= 1'b0;
            ovf       <= 1'b0;
`endif
          end
        end
        S_COMPUTE: begin
          if (w_cnt_hit) begin
            r_bin     <= r_d[0];
            r_bcd     <= '0;
            r_bit_cnt <= '0;
          end else begin
            for (int unsigned k = 0; k < DEGREE; k++) begin
              r_d[k] <= w_sum[k][OUTPUT_WIDTH-1:0];
            end
            r_cnt <= r_cnt + INPUT_WIDTH'(1);
`ifdef BABBAGE_OVF_DETECT_EN
            r_ovf_acc <= r_ovf_acc | w_carry;
`endif
          end
        end
        S_BCD: begin
          r_bcd     <= w_bcd_next;
          r_bin     <= {r_bin[OUTPUT_WIDTH-2:0], 1'b0};
          r_bit_cnt <= r_bit_cnt + BW'(1);
          if (w_bcd_last) begin
            // d[0] is untouched during BCD, so it still holds f(n).
            result  <= r_d[0];
            bcd_out <= w_bcd_next;
`ifdef BABBAGE_OVF_DETECT_EN
            ovf     <= r_ovf_acc;
`endif
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_babbage_poly_engine.sv
// -----------------------------------------------------------------------------
// tb_babbage_poly_engine
//   Scoreboard bench for babbage_poly_engine with f(n) = n^3 + 2n^2 + 2n + 1,
//   init_diff = {1, 5, 10, 6}. The driver pushes hand-computed expectations
//   (result, BCD digits, overflow flag, edge at which done is consumed); a
//   monitor pops and compares on every done pulse.
// -----------------------------------------------------------------------------
module tb_babbage_poly_engine;

  localparam int DG = 3;
  localparam int W  = 14;
  localparam int NW = 5;
  localparam int ND = 5;

  logic                        clk = 1'b0;
  logic                        reset;
  logic                        start;
  logic [NW-1:0]               n_in;
  logic [DG:0][W-1:0]          init_diff;
  logic                        busy;
  logic                        done;
  logic [W-1:0]                result;
  logic [ND-1:0][3:0]          bcd_out;
`ifdef BABBAGE_OVF_DETECT_EN
  logic                        ovf;
`endif

  babbage_poly_engine #(
    .DEGREE      (DG),
    .OUTPUT_WIDTH(W),
    .INPUT_WIDTH (NW),
    .BCD_DIGITS  (ND)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .n_in     (n_in),
    .init_diff(init_diff),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .bcd_out  (bcd_out)
`ifdef BABBAGE_OVF_DETECT_EN
    ,
    .ovf      (ovf)
`endif
  );

  always #5 clk = ~clk;

  // Absolute posedge count; at a negedge it equals the index of the last edge.
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0]    res;
    logic [4*ND-1:0] bcd;
    logic            ovf;
    int unsigned     edge_at;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h (%0d), expected 0x%0h (%0d)", name, act, act, exp, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done) begin
      if (sbq.size() == 0) begin
        check("unexpected_done", 64'd1, 64'd0);
      end else begin
        mon_e = sbq.pop_front();
        check("result", 64'(result), 64'(mon_e.res));
        check("bcd_out", 64'(bcd_out), 64'(mon_e.bcd));
        // done is visible before edge start+n+W+2, which samples it.
        check("done_edge", 64'(cyc + 1), 64'(mon_e.edge_at));
`ifdef BABBAGE_OVF_DETECT_EN
        check("ovf", 64'(ovf), 64'(mon_e.ovf));
`endif
      end
    end
  end

  // Call at a negedge. Drives start for one cycle; returns at the negedge
  // just after the start-sampling edge.
  task automatic issue(input int unsigned n, input logic expect_done,
                       input logic [W-1:0] res, input logic [4*ND-1:0] bcd,
                       input logic ov);
    exp_t e;
    n_in  = NW'(n);
    start = 1'b1;
    if (expect_done) begin
      e.res     = res;
      e.bcd     = bcd;
      e.ovf     = ov;
      e.edge_at = cyc + 1 + n + W + 2;
      sbq.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (sbq.size() == 0 && !busy) return;
    end
    check("wait_idle_timeout", 64'd1, 64'd0);
    sbq.delete();
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_result"}, 64'(result), 64'd0);
    check({tag, "_bcd"}, 64'(bcd_out), 64'd0);
`ifdef BABBAGE_OVF_DETECT_EN
    check({tag, "_ovf"}, 64'(ovf), 64'd0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset        = 1'b1;
    start        = 1'b0;
    n_in         = '0;
    init_diff[0] = W'(1);
    init_diff[1] = W'(5);
    init_diff[2] = W'(10);
    init_diff[3] = W'(6);

    #1;
    check_reset_state("reset");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // n=5: f=186, busy seen by edges 1..21, low from edge 22.
    issue(5, 1'b1, W'(186), 20'h00186, 1'b0);
    check("busy_e1", 64'(busy), 64'd1);
    for (int i = 1; i <= 21; i++) begin
      @(negedge clk);
      check($sformatf("busy_e%0d", i + 1), 64'(busy), (i <= 20) ? 64'd1 : 64'd0);
    end
    wait_idle();

    // n=0: result is f(0) after one COMPUTE cycle.
    @(negedge clk);
    issue(0, 1'b1, W'(1), 20'h00001, 1'b0);
    wait_idle();

    // n=20: f=8841, no overflow; a start pulse mid-COMPUTE must be ignored.
    @(negedge clk);
    issue(20, 1'b1, W'(8841), 20'h08841, 1'b0);
    repeat (5) @(negedge clk);
    n_in  = NW'(7);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    check("result_after_ignored_start", 64'(result), 64'd8841);

    // n=25: f=16926 wraps to 542; overflow flagged when present.
    @(negedge clk);
    issue(25, 1'b1, W'(542), 20'h00542, 1'b1);
    wait_idle();

    // Reset in the middle of BCD: outputs clear at once, no done pulse.
    @(negedge clk);
    issue(5, 1'b0, '0, '0, 1'b0);
    repeat (10) @(negedge clk);
    check("busy_before_abort", 64'(busy), 64'd1);
    #2;
    reset = 1'b1;
    #1;
    check_reset_state("abort");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    // Start sampled on the very first edge after release.
    issue(3, 1'b1, W'(52), 20'h00052, 1'b0);
    wait_idle();

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
